// File: rtl/fft_rad2_iter_pkg.sv
// Shared types and helpers for the iterative radix-2 FFT.
package fft_rad2_iter_pkg;

  localparam int Q_FRAC = 8;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_fixed_t;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } complex_product_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } fft_state_e;

  // Reverse the low 'bits' bits of v.
  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      r = r | (((v >> b) & 1) << (bits - 1 - b));
    end
    return r;
  endfunction

  // Clamp to the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input int v);
    logic signed [15:0] r;
    if (v > 32767)       r = 16'sh7fff;
    else if (v < -32768) r = 16'sh8000;
    else                 r = v[15:0];
    return r;
  endfunction

  // True when sat16 would clip v.
  function automatic logic is_sat16(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Drop the Q_FRAC fraction bits of a full-precision product, rounding half up.
  function automatic int round_q(input int v);
    return (v + (1 << (Q_FRAC - 1))) >>> Q_FRAC;
  endfunction

  // Optional per-stage halving with rounding.
  function automatic int scale_half(input int v, input logic en);
    return en ? ((v + 1) >>> 1) : v;
  endfunction

  // Nearest-integer conversion used when building the twiddle ROM.
  function automatic int round_real(input real x);
    int r;
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = $rtoi(x - 0.5);
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_r2.sv
// Registered radix-2 DIT butterfly: x = a + b*W, y = a - b*W, with
// optional conjugated twiddle, optional halving and saturation reporting.
module fft_butterfly_r2
  import fft_rad2_iter_pkg::*;
(
  input  logic           clk,
  input  logic           i_en,
  input  complex_fixed_t i_a,
  input  complex_fixed_t i_b,
  input  complex_fixed_t i_w,
  input  logic           i_inverse,
  input  logic           i_scale_en,
  output complex_fixed_t o_x,
  output complex_fixed_t o_y,
  output logic           o_sat
);

  int               w_wr;
  int               w_wi;
  complex_product_t w_prod;
  int               w_p_re;
  int               w_p_im;
  complex_fixed_t   w_p;
  int               w_x_re;
  int               w_x_im;
  int               w_y_re;
  int               w_y_im;
  logic             w_sat;

  // Complex multiply, round, then add/subtract with optional halving.
  always_comb begin
    w_wr      = int'(i_w.re);
    w_wi      = i_inverse ? -int'(i_w.im) : int'(i_w.im);
    w_prod.re = int'(i_b.re) * w_wr - int'(i_b.im) * w_wi;
    w_prod.im = int'(i_b.re) * w_wi + int'(i_b.im) * w_wr;
    w_p_re    = round_q(int'(w_prod.re));
    w_p_im    = round_q(int'(w_prod.im));
    w_p.re    = sat16(w_p_re);
    w_p.im    = sat16(w_p_im);
    w_x_re    = scale_half(int'(i_a.re) + int'(w_p.re), i_scale_en);
    w_x_im    = scale_half(int'(i_a.im) + int'(w_p.im), i_scale_en);
    w_y_re    = scale_half(int'(i_a.re) - int'(w_p.re), i_scale_en);
    w_y_im    = scale_half(int'(i_a.im) - int'(w_p.im), i_scale_en);
    w_sat     = is_sat16(w_p_re) | is_sat16(w_p_im) |
                is_sat16(w_x_re) | is_sat16(w_x_im) |
                is_sat16(w_y_re) | is_sat16(w_y_im);
  end

  // Single pipeline register; holds while the block is paused.
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_x.re <= sat16(w_x_re);
      o_x.im <= sat16(w_x_im);
      o_y.re <= sat16(w_y_re);
      o_y.im <= sat16(w_y_im);
      o_sat  <= w_sat;
    end
  end

endmodule

// File: rtl/fft_rad2_iter.sv
// Memory-based iterative radix-2 DIT FFT/IFFT. Samples are loaded at
// bit-reversed addresses, processed in place stage by stage through one
// shared butterfly, and streamed out in natural order.
module fft_rad2_iter
  import fft_rad2_iter_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  complex_fixed_t   in_data,
  input  logic             inverse,
  input  logic             scale_en,
  output logic             out_valid,
  input  logic             out_ready,
  output complex_fixed_t   out_data,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             ovf
);

  localparam logic [LOG2N-1:0] K_DRAIN    = LOG2N'(N / 2);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
  localparam real              TWO_PI     = 6.283185307179586;

  fft_state_e       r_state;
  fft_state_e       w_state_next;
  logic [LOG2N-1:0] r_n;
  logic [LOG2N-1:0] r_k;
  logic [LOG2N-1:0] r_stage;
  logic [LOG2N-1:0] r_out_idx;
  logic             r_inverse;
  logic             r_scale;
  logic             r_ovf;
  logic             r_wb_valid;
  logic [LOG2N-1:0] r_wb_top;
  logic [LOG2N-1:0] r_wb_bot;
  complex_fixed_t   r_mem [N];

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_issue;
  logic             w_stage_done;
  logic [LOG2N-1:0] w_load_addr;
  logic [LOG2N-1:0] w_span_mask;
  logic [LOG2N-1:0] w_lo;
  logic [LOG2N-1:0] w_top;
  logic [LOG2N-1:0] w_bot;
  logic [LOG2N-1:0] w_tw_idx;
  complex_fixed_t   w_tw [N];
  complex_fixed_t   w_bf_x;
  complex_fixed_t   w_bf_y;
  logic             w_bf_sat;

  // Twiddle ROM W^j = exp(-2*pi*i*j/N) in Q7.8, built at elaboration.
  // A full turn is stored so the index needs no truncation; only the
  // lower half is ever addressed.
  for (genvar gi = 0; gi < N; gi++) begin : g_tw
    localparam real ANG   = TWO_PI * real'(gi) / real'(N);
    localparam real ONE   = real'(1 << Q_FRAC);
    localparam int  TW_RE = round_real(ONE * $cos(ANG));
    localparam int  TW_IM = round_real(-ONE * $sin(ANG));
    assign w_tw[gi] = {TW_RE[15:0], TW_IM[15:0]};
  end

  // Butterfly addressing: top = (k & ~mask) << 1 | (k & mask), bot = top + span,
  // twiddle index = (k & mask) * N / (2*span).
  always_comb begin
    w_span_mask = (LOG2N'(1) << r_stage) - LOG2N'(1);
    w_lo        = r_k & w_span_mask;
    w_top       = ((r_k & ~w_span_mask) << 1) | w_lo;
    w_bot       = w_top | (LOG2N'(1) << r_stage);
    w_tw_idx    = w_lo << (LAST_STAGE - r_stage);
    w_load_addr = LOG2N'(bitrev(int'(r_n), LOG2N));
  end

  assign w_issue      = (r_state == COMPUTE) && (r_k != K_DRAIN);
  assign w_stage_done = (r_state == COMPUTE) && (r_k == K_DRAIN);
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;

  fft_butterfly_r2 u_bf (
    .clk        (clk),
    .i_en       (enable),
    .i_a        (r_mem[w_top]),
    .i_b        (r_mem[w_bot]),
    .i_w        (w_tw[w_tw_idx]),
    .i_inverse  (r_inverse),
    .i_scale_en (r_scale),
    .o_x        (w_bf_x),
    .o_y        (w_bf_y),
    .o_sat      (w_bf_sat)
  );

  // State register; frozen while enable is low.
  always_ff @(posedge clk) begin
    if (reset)       r_state <= LOAD;
    else if (enable) r_state <= w_state_next;
  end

  // Next-state logic and handshake/status outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_last     = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = enable;
        if (in_valid && enable && (r_n == LAST_IDX)) w_state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (w_stage_done && (r_stage == LAST_STAGE)) w_state_next = UNLOAD;
      end
      UNLOAD: begin
        out_valid = enable;
        out_last  = (r_out_idx == LAST_IDX);
        if (enable && out_ready && (r_out_idx == LAST_IDX)) w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
  end

  // Input sample counter and per-frame mode capture on the first sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n       <= '0;
      r_inverse <= 1'b0;
      r_scale   <= 1'b0;
    end else if (enable && w_in_fire) begin
      r_n <= r_n + LOG2N'(1);
      if (r_n == '0) begin
        r_inverse <= inverse;
        r_scale   <= scale_en;
      end
    end
  end

  // Sticky saturation flag, cleared when a new frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (enable) begin
      if (w_in_fire && (r_n == '0))       r_ovf <= 1'b0;
      else if (r_wb_valid && w_bf_sat)    r_ovf <= 1'b1;
    end
  end

  // Stage/butterfly sequencer: N/2 issues then one drain cycle per stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_stage <= '0;
    end else if (enable && (r_state == COMPUTE)) begin
      if (w_stage_done) begin
        r_k     <= '0;
        r_stage <= (r_stage == LAST_STAGE) ? '0 : r_stage + LOG2N'(1);
      end else begin
        r_k <= r_k + LOG2N'(1);
      end
    end
  end

  // Write-back addresses follow the butterfly by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_top   <= '0;
      r_wb_bot   <= '0;
    end else if (enable) begin
      r_wb_valid <= w_issue;
      r_wb_top   <= w_top;
      r_wb_bot   <= w_bot;
    end
  end

  // Output bin counter; wraps to 0 after the last bin.
  always_ff @(posedge clk) begin
    if (reset)                     r_out_idx <= '0;
    else if (enable && w_out_fire) r_out_idx <= r_out_idx + LOG2N'(1);
  end

  // In-place sample buffer: loads at bit-reversed address, butterfly write-back.
  always_ff @(posedge clk) begin
    if (enable) begin
      if (w_in_fire) r_mem[w_load_addr] <= in_data;
      if (r_wb_valid) begin
        r_mem[r_wb_top] <= w_bf_x;
        r_mem[r_wb_bot] <= w_bf_y;
      end
    end
  end

  assign out_data  = (r_state == UNLOAD) ? r_mem[r_out_idx] : '0;
  assign out_index = r_out_idx;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fft_rad2_iter.sv
// Self-checking bench for fft_rad2_iter (N=8) against a loop-based FFT model.
module tb_fft_rad2_iter;
  import fft_rad2_iter_pkg::*;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int HALF  = N / 2;
  localparam int COMPUTE_CYC = LOG2N * (HALF + 1);

  logic             clk = 1'b0;
  logic             reset, enable, in_valid, in_ready, inverse, scale_en;
  logic             out_valid, out_ready, out_last, busy, ovf;
  complex_fixed_t   in_data, out_data;
  logic [LOG2N-1:0] out_index;

  int checks = 0;
  int errors = 0;
  int tw_re [N];
  int tw_im [N];
  bit m_ovf;

  int xr [N], xi [N], cr [N], ci [N], fr [N], fi [N];

  always #5 clk = ~clk;

  fft_rad2_iter #(.N(N)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inverse(inverse), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (v & (1 << b)) r += 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic int sat_m(input int v);
    if (v > 32767)  begin m_ovf = 1'b1; return 32767;  end
    if (v < -32768) begin m_ovf = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic int half_m(input int v, input bit sc);
    return sc ? ((v + 1) >>> 1) : v;
  endfunction

  // Reference FFT: classic group/offset DIT loops on plain integer arrays.
  function automatic void ref_fft(input int ir [N], input int ii [N], input bit inv, input bit sc,
                                  output int orr [N], output int oi [N], output bit of);
    int ar [N], ai [N];
    int span, t, b, wr, wi, p_r, p_i, a_r, a_i;
    m_ovf = 1'b0;
    for (int n = 0; n < N; n++) begin ar[rev(n)] = ir[n]; ai[rev(n)] = ii[n]; end
    for (int s = 0; s < LOG2N; s++) begin
      span = 1 << s;
      for (int g = 0; g < N; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          t   = g + j;
          b   = t + span;
          wr  = tw_re[j * (N / (2 * span))];
          wi  = inv ? -tw_im[j * (N / (2 * span))] : tw_im[j * (N / (2 * span))];
          p_r = sat_m((ar[b] * wr - ai[b] * wi + 128) >>> 8);
          p_i = sat_m((ar[b] * wi + ai[b] * wr + 128) >>> 8);
          a_r = ar[t];
          a_i = ai[t];
          ar[t] = sat_m(half_m(a_r + p_r, sc));
          ai[t] = sat_m(half_m(a_i + p_i, sc));
          ar[b] = sat_m(half_m(a_r - p_r, sc));
          ai[b] = sat_m(half_m(a_i - p_i, sc));
        end
      end
    end
    orr = ar;
    oi  = ai;
    of  = m_ovf;
  endfunction

  task automatic load_frame(input int lr [N], input int li [N], input bit inv, input bit sc);
    for (int n = 0; n < N; n++) begin
      while ($urandom_range(3) == 0) begin in_valid = 1'b0; @(negedge clk); end
      chk("in_ready_load", in_ready, 1);
      in_valid   = 1'b1;
      in_data.re = 16'(lr[n]);
      in_data.im = 16'(li[n]);
      inverse    = (n == 0) ? inv : 1'($urandom_range(1));
      scale_en   = (n == 0) ? sc  : 1'($urandom_range(1));
      @(negedge clk);
      if (n == 0) chk("ovf_cleared_first_sample", ovf, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int stall_at);
    int lat  = 0;
    int bcnt = 0;
    int extra;
    extra = (stall_at >= 0) ? 3 : 0;
    while (!out_valid && lat < 400) begin
      if (lat == stall_at)     enable = 1'b0;
      if (lat == stall_at + 3) enable = 1'b1;
      chk("in_ready_compute", in_ready, 0);
      bcnt += int'(busy);
      in_valid   = 1'($urandom_range(1));
      in_data.re = 16'($urandom);
      in_data.im = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    enable = 1'b1;
    chk("latency", lat + 1, 1 + COMPUTE_CYC + extra);
    chk("busy_cycles", bcnt, COMPUTE_CYC + extra);
  endtask

  task automatic unload_frame(input string name, input int er [N], input int ei [N], input bit eovf,
                              input int mode, output int gr [N], output int gi [N]);
    int  idx = 0;
    int  guard = 0;
    bit  rdy;
    in_valid = 1'b0;
    while (idx < N && guard < 200) begin
      chk($sformatf("%s.out_valid", name), out_valid, 1);
      chk($sformatf("%s.index", name), out_index, idx);
      chk($sformatf("%s.re[%0d]", name, idx), out_data.re, er[idx]);
      chk($sformatf("%s.im[%0d]", name, idx), out_data.im, ei[idx]);
      chk($sformatf("%s.last[%0d]", name, idx), out_last, (idx == N - 1) ? 1 : 0);
      chk($sformatf("%s.ovf", name), ovf, eovf);
      chk($sformatf("%s.busy", name), busy, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 3 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      gr[idx]   = out_data.re;
      gi[idx]   = out_data.im;
      out_ready = rdy;
      @(negedge clk);
      guard++;
      if (rdy) idx++;
    end
    out_ready = 1'b0;
    chk($sformatf("%s.done_in_ready", name), in_ready, 1);
    chk($sformatf("%s.done_out_valid", name), out_valid, 0);
    $display("frame %s: %0d bins received, checks=%0d errors=%0d", name, idx, checks, errors);
  endtask

  task automatic run_frame(input string name, input int rr [N], input int ri [N], input bit inv,
                           input bit sc, input int mode, input int stall,
                           output int gr [N], output int gi [N]);
    int er [N], ei [N];
    bit eo;
    ref_fft(rr, ri, inv, sc, er, ei, eo);
    load_frame(rr, ri, inv, sc);
    wait_out(stall);
    unload_frame(name, er, ei, eo, mode, gr, gi);
  endtask

  initial begin
    real ang;
    int  cosv [N];
    cosv = '{256, 181, 0, -181, -256, -181, 0, 181};
    for (int j = 0; j < N; j++) begin
      ang      = 6.283185307179586 * j / N;
      tw_re[j] = $rtoi(256.0 * $cos(ang) + ((256.0 * $cos(ang) >= 0.0) ? 0.5 : -0.5));
      tw_im[j] = $rtoi(-256.0 * $sin(ang) + ((-256.0 * $sin(ang) >= 0.0) ? 0.5 : -0.5));
    end
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    inverse = 1'b0; scale_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_last", out_last, 0);
    chk("rst.out_index", out_index, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ovf", ovf, 0);
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    #1 chk("enable_low.in_ready", in_ready, 0);
    enable = 1'b1;
    @(negedge clk);

    // Impulse
    for (int n = 0; n < N; n++) begin xr[n] = (n == 0) ? 256 : 0; xi[n] = 0; end
    run_frame("impulse", xr, xi, 0, 0, 0, -1, cr, ci);
    for (int n = 0; n < N; n++) begin
      chk("impulse.bin_re", cr[n], 256);
      chk("impulse.bin_im", ci[n], 0);
    end

    // DC, unscaled and scaled
    for (int n = 0; n < N; n++) begin xr[n] = 256; xi[n] = 0; end
    run_frame("dc", xr, xi, 0, 0, 0, -1, cr, ci);
    chk("dc.X0", cr[0], 2048);
    chk("dc.X3", cr[3], 0);
    run_frame("dc_scaled", xr, xi, 0, 1, 2, -1, cr, ci);
    chk("dc_scaled.X0", cr[0], 256);

    // Cosine with stalling consumer, then inverse round trip of the model spectrum
    for (int n = 0; n < N; n++) begin xr[n] = cosv[n]; xi[n] = 0; end
    run_frame("cosine", xr, xi, 0, 0, 1, -1, cr, ci);
    begin
      bit eo;
      ref_fft(xr, xi, 0, 0, fr, fi, eo);
    end
    run_frame("roundtrip", fr, fi, 1, 1, 1, -1, cr, ci);

    // Overflow, then impulse clears the flag on its first sample
    for (int n = 0; n < N; n++) begin xr[n] = 32767; xi[n] = 0; end
    run_frame("overflow", xr, xi, 0, 0, 0, -1, cr, ci);
    chk("overflow.X0", cr[0], 32767);
    chk("overflow.ovf_held", ovf, 1);
    for (int n = 0; n < N; n++) begin xr[n] = (n == 0) ? 256 : 0; xi[n] = 0; end
    run_frame("impulse2", xr, xi, 0, 0, 2, -1, cr, ci);
    chk("impulse2.bin5", cr[5], 256);

    // enable pause mid-COMPUTE and random frames
    for (int f = 0; f < 5; f++) begin
      for (int n = 0; n < N; n++) begin
        xr[n] = (f == 4) ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(8000)) - 4000;
        xi[n] = (f == 4) ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(8000)) - 4000;
      end
      run_frame($sformatf("rand%0d", f), xr, xi, 1'($urandom_range(1)), 1'($urandom_range(1)),
                2, (f == 1) ? 5 : -1, cr, ci);
    end

    // Reset mid-COMPUTE after saturation has already been flagged
    for (int n = 0; n < N; n++) begin xr[n] = 32767; xi[n] = 32767; end
    load_frame(xr, xi, 0, 0);
    repeat (5) @(negedge clk);
    chk("midreset.busy_before", busy, 1);
    chk("midreset.ovf_before", ovf, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset.in_ready", in_ready, 1);
    chk("midreset.busy", busy, 0);
    chk("midreset.out_valid", out_valid, 0);
    chk("midreset.ovf", ovf, 0);
    chk("midreset.out_index", out_index, 0);
    chk("midreset.out_data", out_data, 0);
    for (int n = 0; n < N; n++) begin
      xr[n] = int'($urandom_range(2000)) - 1000;
      xi[n] = int'($urandom_range(2000)) - 1000;
    end
    run_frame("after_reset", xr, xi, 0, 1, 0, -1, cr, ci);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
